// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Data memory behind a request/ready handshake. Each request takes LATENCY
//   edges to complete. The block supports byte, halfword and word accesses
//   with byte-lane writes and sign- or zero-extended loads. The memory is
//   relocated to BASE_ADDR. Misaligned and out-of-range accesses are rejected
//   with FAULT.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for REQ; the request fields are latched on acceptance
//   BUSY  | counting down the access latency; responds when counter == 0
//
// Ports
//   CLK    clock; all state updates on the rising edge
//   RST    synchronous reset, active-high; memory contents are preserved
//   REQ    access request, sampled only in IDLE
//   RW     0 = read, 1 = write
//   SIZE   00 byte, 01 halfword, 10 word, 11 illegal
//   UNS    1 = zero-extend loads, 0 = sign-extend (ignored for words)
//   ADDR   byte address
//   WD     write data, right-justified
//   RD     read data, valid while READY=1 and FAULT=0; held until next response
//   READY  one-cycle response pulse
//   FAULT  valid with READY; 1 = access rejected
//
// Parameters
//   DEPTH_LOG2  log2 of the number of 32-bit words
//   BASE_ADDR   byte address of word 0; must be 4-byte aligned
//   LATENCY     edges from acceptance to response; legal range 1..15
module data_mem_ctrl #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        RW,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] ADDR,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        READY,
    output logic        FAULT
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        rw_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;

    logic [31:0] rd_d;
    logic        ready_d;
    logic        fault_d;
    logic        latch_en;
    logic        mem_we;

    logic [31:0] mem [2**DEPTH_LOG2];

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  in_range;
    logic                  misaligned;
    logic                  fault_c;
    logic [31:0]           mem_word;
    logic [31:0]           shifted;
    logic [31:0]           load_data;
    logic [31:0]           wr_data;
    logic [3:0]            wr_be;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    assign off      = addr_q - BASE_ADDR;
    assign idx      = off[DEPTH_LOG2+1:2];
    assign lane     = off[1:0];
    assign in_range = (off >> (DEPTH_LOG2 + 2)) == 32'd0;

    always_comb begin
        misaligned = 1'b0;
        case (size_q)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = (lane != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    assign fault_c = !in_range || misaligned;

    // Little-endian: lane 0 is bits [7:0], so shift the addressed lane down.
    assign mem_word = mem[idx];
    assign shifted  = mem_word >> {lane, 3'b000};

    always_comb begin
        load_data = mem_word;
        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = uns_q ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = mem_word;
        endcase
    end

    // Replicate the narrow data to every lane; the byte enables pick the lanes.
    always_comb begin
        wr_data = wd_q;
        wr_be   = 4'b1111;
        case (size_q)
            2'b00: begin
                wr_data = {4{wd_q[7:0]}};
                wr_be   = 4'b0001 << lane;
            end
            2'b01: begin
                wr_data = {2{wd_q[15:0]}};
                wr_be   = 4'b0011 << lane;
            end
            default: begin
                wr_data = wd_q;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_d     = RD;
        fault_d  = FAULT;
        ready_d  = 1'b0;
        latch_en = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ) begin
                    latch_en = 1'b1;
                    cnt_d    = 4'(LATENCY - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    if (fault_c) begin
                        rd_d    = 32'h0;
                        fault_d = 1'b1;
                    end else if (rw_q) begin
                        mem_we  = 1'b1;
                        rd_d    = 32'h0;
                        fault_d = 1'b0;
                    end else begin
                        rd_d    = load_data;
                        fault_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            RD      <= 32'h0;
            READY   <= 1'b0;
            FAULT   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            RD      <= rd_d;
            READY   <= ready_d;
            FAULT   <= fault_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (latch_en && !RST) begin
            rw_q   <= RW;
            size_q <= SIZE;
            uns_q  <= UNS;
            addr_q <= ADDR;
            wd_q   <= WD;
        end
    end

    // A reset coinciding with the commit edge discards the write.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NDUT = 5;

    logic        clk;
    logic        rst   [NDUT];
    logic        req   [NDUT];
    logic        rw    [NDUT];
    logic [1:0]  size  [NDUT];
    logic        uns   [NDUT];
    logic [31:0] addr  [NDUT];
    logic [31:0] wd    [NDUT];
    logic [31:0] rd    [NDUT];
    logic        ready [NDUT];
    logic        fault [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    // Instance latencies: 0 -> 1, 1 -> 2, 2 -> 3, 3 -> 4, 4 -> 15
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 :
                             (g == 3) ? 4 : 15;
        data_mem_ctrl #(
            .DEPTH_LOG2(10),
            .BASE_ADDR (BASE),
            .LATENCY   (LAT)
        ) u_dut (
            .CLK  (clk),
            .RST  (rst[g]),
            .REQ  (req[g]),
            .RW   (rw[g]),
            .SIZE (size[g]),
            .UNS  (uns[g]),
            .ADDR (addr[g]),
            .WD   (wd[g]),
            .RD   (rd[g]),
            .READY(ready[g]),
            .FAULT(fault[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        case (d)
            0: return 1;
            1: return 2;
            2: return 3;
            3: return 4;
            default: return 15;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int d, input logic rw_i, input logic [1:0] sz,
                              input logic un, input logic [31:0] a, input logic [31:0] w);
        rw[d]   = rw_i;
        size[d] = sz;
        uns[d]  = un;
        addr[d] = a;
        wd[d]   = w;
    endtask

    // One access: checks latency, response data/fault, single-cycle READY
    // and that RD/FAULT hold afterwards.
    task automatic access(input int d, input logic rw_i, input logic [1:0] sz,
                          input logic un, input logic [31:0] a, input logic [31:0] w,
                          input logic toggle, input logic [31:0] exp_rd,
                          input logic exp_fault, input string tag);
        int n;
        int extra;
        bit got;
        @(negedge clk);
        set_fields(d, rw_i, sz, un, a, w);
        req[d] = 1'b1;
        @(posedge clk);
        #1;
        req[d] = 1'b0;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            if (toggle) req[d] = ~req[d];
            @(posedge clk);
            #1;
            n++;
            if (ready[d] === 1'b1) got = 1;
        end
        req[d] = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(lat_of(d)));
        chk({tag, " rd"}, rd[d], exp_rd);
        chk({tag, " fault"}, {31'h0, fault[d]}, {31'h0, exp_fault});
        extra = 0;
        for (int i = 0; i < lat_of(d) + 2; i++) begin
            @(posedge clk);
            #1;
            if (ready[d] !== 1'b0) extra++;
        end
        chk({tag, " extra ready"}, 32'(extra), 32'h0);
        chk({tag, " rd hold"}, rd[d], exp_rd);
    endtask

    logic        b_rw  [4];
    logic [31:0] b_adr [4];
    logic [31:0] b_wd  [4];
    logic [31:0] b_exp [4];

    initial begin
        int k;
        int n;
        int last;
        int extra;

        for (int i = 0; i < NDUT; i++) begin
            rst[i] = 1'b1;
            req[i] = 1'b0;
            set_fields(i, 1'b0, 2'b10, 1'b0, BASE, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("reset ready[%0d]", i), {31'h0, ready[i]}, 32'h0);
            chk($sformatf("reset fault[%0d]", i), {31'h0, fault[i]}, 32'h0);
            chk($sformatf("reset rd[%0d]", i), rd[i], 32'h0);
        end
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) rst[i] = 1'b0;

        // Word write/read and lane tests, LATENCY=1
        access(0, 1, 2'b10, 0, BASE + 8,  32'hDEADBEEF, 0, 32'h0,        0, "sw +8");
        access(0, 0, 2'b10, 0, BASE + 8,  32'h0,        0, 32'hDEADBEEF, 0, "lw +8");
        access(0, 1, 2'b10, 0, BASE + 12, 32'hDEADBEEF, 0, 32'h0,        0, "sw +12");
        access(0, 1, 2'b00, 0, BASE + 13, 32'hAAAAAA80, 0, 32'h0,        0, "sb +13");
        access(0, 0, 2'b10, 0, BASE + 12, 32'h0,        0, 32'hDEAD80EF, 0, "lw +12");
        access(0, 0, 2'b00, 0, BASE + 13, 32'h0,        0, 32'hFFFFFF80, 0, "lb +13");
        access(0, 0, 2'b00, 1, BASE + 13, 32'h0,        0, 32'h00000080, 0, "lbu +13");
        access(0, 0, 2'b01, 0, BASE + 14, 32'h0,        0, 32'hFFFFDEAD, 0, "lh +14");
        access(0, 0, 2'b01, 1, BASE + 14, 32'h0,        0, 32'h0000DEAD, 0, "lhu +14");
        access(0, 0, 2'b01, 0, BASE + 12, 32'h0,        0, 32'hFFFF80EF, 0, "lh +12");
        access(0, 1, 2'b01, 0, BASE + 14, 32'h55551234, 0, 32'h0,        0, "sh +14");
        access(0, 0, 2'b10, 0, BASE + 12, 32'h0,        0, 32'h123480EF, 0, "lw +12 after sh");

        // Faults and range boundaries
        access(0, 1, 2'b10, 0, BASE + 0,    32'hCAFEF00D, 0, 32'h0, 0, "sw +0");
        access(0, 0, 2'b10, 0, BASE + 8,    32'h0,        0, 32'hDEADBEEF, 0, "lw +8 again");
        access(0, 0, 2'b10, 0, BASE + 2,    32'h0,        0, 32'h0, 1, "lw +2 misaligned");
        access(0, 0, 2'b00, 0, BASE + 8,    32'h0,        0, 32'hFFFFFFEF, 0, "lb +8");
        access(0, 0, 2'b01, 0, BASE + 1,    32'h0,        0, 32'h0, 1, "lh +1 misaligned");
        access(0, 0, 2'b11, 0, BASE + 0,    32'h0,        0, 32'h0, 1, "size 11");
        access(0, 0, 2'b10, 0, BASE + 4096, 32'h0,        0, 32'h0, 1, "lw +4096");
        access(0, 0, 2'b10, 0, BASE - 4,    32'h0,        0, 32'h0, 1, "lw base-4");
        access(0, 1, 2'b10, 0, BASE + 4096, 32'h11111111, 0, 32'h0, 1, "sw +4096");
        access(0, 0, 2'b10, 0, BASE + 0,    32'h0,        0, 32'hCAFEF00D, 0, "lw +0 unchanged");
        access(0, 1, 2'b10, 0, BASE + 4092, 32'h0BADC0DE, 0, 32'h0, 0, "sw last word");
        access(0, 0, 2'b10, 0, BASE + 4092, 32'h0,        0, 32'h0BADC0DE, 0, "lw last word");

        // Latency sweep with REQ toggling while busy
        access(0, 1, 2'b10, 0, BASE + 16, 32'h01020304, 1, 32'h0,        0, "L1 sw toggle");
        access(0, 0, 2'b10, 0, BASE + 16, 32'h0,        1, 32'h01020304, 0, "L1 lw toggle");
        access(2, 1, 2'b10, 0, BASE + 64, 32'hA5A55A5A, 1, 32'h0,        0, "L3 sw toggle");
        access(2, 0, 2'b10, 0, BASE + 64, 32'h0,        1, 32'hA5A55A5A, 0, "L3 lw toggle");
        access(4, 1, 2'b10, 0, BASE + 68, 32'h0F0FF0F0, 1, 32'h0,        0, "L15 sw toggle");
        access(4, 0, 2'b00, 1, BASE + 69, 32'h0,        1, 32'h000000F0, 0, "L15 lbu toggle");

        // Back-to-back, LATENCY=2, REQ held high
        b_rw[0] = 1; b_adr[0] = BASE + 32'h20; b_wd[0] = 32'h11223344; b_exp[0] = 32'h0;
        b_rw[1] = 1; b_adr[1] = BASE + 32'h24; b_wd[1] = 32'h55667788; b_exp[1] = 32'h0;
        b_rw[2] = 0; b_adr[2] = BASE + 32'h20; b_wd[2] = 32'h0;        b_exp[2] = 32'h11223344;
        b_rw[3] = 0; b_adr[3] = BASE + 32'h24; b_wd[3] = 32'h0;        b_exp[3] = 32'h55667788;
        @(negedge clk);
        set_fields(1, b_rw[0], 2'b10, 0, b_adr[0], b_wd[0]);
        req[1] = 1'b1;
        @(posedge clk);
        #1;
        k = 0;
        n = 0;
        last = 0;
        while (k < 4 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (ready[1] === 1'b1) begin
                chk($sformatf("b2b rd %0d", k), rd[1], b_exp[k]);
                chk($sformatf("b2b fault %0d", k), {31'h0, fault[1]}, 32'h0);
                chk($sformatf("b2b spacing %0d", k), 32'(n - last), (k == 0) ? 32'd2 : 32'd3);
                last = n;
                k++;
                if (k < 4) set_fields(1, b_rw[k], 2'b10, 0, b_adr[k], b_wd[k]);
                else req[1] = 1'b0;
            end
        end
        req[1] = 1'b0;
        chk("b2b pulse count", 32'(k), 32'd4);

        // Reset mid-operation, LATENCY=4
        access(3, 1, 2'b10, 0, BASE + 0, 32'h0, 0, 32'h0, 0, "L4 clear +0");
        @(negedge clk);
        set_fields(3, 1, 2'b10, 0, BASE + 0, 32'h12345678);
        req[3] = 1'b1;
        @(posedge clk);
        #1;
        req[3] = 1'b0;
        @(posedge clk);
        #1;
        rst[3] = 1'b1;
        @(posedge clk);
        #1;
        rst[3] = 1'b0;
        chk("midrst ready", {31'h0, ready[3]}, 32'h0);
        chk("midrst fault", {31'h0, fault[3]}, 32'h0);
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ready[3] !== 1'b0) extra++;
        end
        chk("midrst no ready", 32'(extra), 32'h0);
        access(3, 0, 2'b10, 0, BASE + 0, 32'h0, 0, 32'h0, 0, "midrst lw +0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory used by the datapath.
- Adds a request/ready handshake with configurable access latency and byte/halfword/word accesses with byte-lane writes.
- Adds sign/zero-extended loads, a relocatable base address, and fault reporting for misaligned or out-of-range accesses.
- Sits between the CPU MEM stage and on-chip data storage; the stage stalls until READY.

Parameters:
- DEPTH_LOG2, 10: log2 of the number of 32-bit words (default 1024 words, 4 KiB).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- LATENCY, 1: edges from request acceptance to response; legal range 1..15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ  in  1  access request; sampled only in IDLE.
- RW  in  1  0 = read, 1 = write.
- SIZE  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- UNS  in  1  read extension: 1 = zero-extend, 0 = sign-extend (ignored for word accesses).
- ADDR  in  32  byte address.
- WD  in  32  write data, right-justified (byte in WD[7:0], halfword in WD[15:0]).
- RD  out  32  read data; valid only while READY=1 and FAULT=0.
- READY  out  1  one-cycle response pulse.
- FAULT  out  1  valid with READY; 1 = access rejected.

Behaviour:
- Reset: RST high at an edge forces state IDLE, READY=0, FAULT=0, RD=0 and counter=0. Memory contents are not cleared.
- Reset mid-operation: an uncommitted write is discarded and no READY is produced.
- Offset: off = ADDR - BASE_ADDR, 32-bit unsigned wrap. An address below BASE_ADDR wraps to a large offset and therefore faults.
- Range rule: the access is in range iff off < 4*2^DEPTH_LOG2. Word index = off[DEPTH_LOG2+1:2]; lane = off[1:0].
- Fault conditions:
  - out of range;
  - SIZE=11;
  - halfword with lane[0]=1;
  - word with lane != 0.
- States: IDLE, BUSY.
- IDLE:
  - If REQ=1 at an edge, latch RW, SIZE, UNS, ADDR and WD, load counter = LATENCY-1, go to BUSY.
  - The fault check runs on the latched values.
  - REQ=0: remain in IDLE.
- BUSY, counter != 0: decrement the counter. REQ is ignored; there is no queueing.
- BUSY, counter == 0, at the edge:
  - Fault: no memory write; RD=0, FAULT=1, READY=1.
  - Write: update only the addressed lanes — byte writes WD[7:0] to lane; halfword writes WD[15:0] to lanes lane and lane+1; word writes all four. Then RD=0, FAULT=0, READY=1.
  - Read: RD = selected byte/halfword/word, extended per UNS; FAULT=0, READY=1.
  - Return to IDLE.
- Byte order is little-endian: lane 0 = bits [7:0].
- Latency: READY rises exactly LATENCY edges after the edge that accepts REQ, and is high for exactly one cycle.
- Back-to-back: when REQ=1 in IDLE at the edge where READY is high, the next request is accepted. Throughput is one access per LATENCY+1 cycles.
- Outputs: RD and FAULT hold their values until the next response or reset. READY is 0 in all cycles other than the response cycle.
- Read-after-write: a read issued after the write's READY returns the new data.

Test Plan:
- Reset then word write/read: write ADDR=BASE+8, WD=32'hDEADBEEF, SIZE=10; read back. Required: READY exactly LATENCY edges after each acceptance, RD=32'hDEADBEEF, FAULT=0.
- Byte lanes and extension:
  - sb 8'h80 to BASE+13, then lw BASE+12 -> RD=32'hDEAD80EF.
  - lb BASE+13 with UNS=0 -> 32'hFFFFFF80; lbu -> 32'h00000080.
  - lh BASE+14, UNS=0 -> 32'hFFFFDEAD.
- Faults:
  - lw BASE+2, lh BASE+1, SIZE=11, ADDR=BASE+4096 (DEPTH_LOG2=10) and ADDR=BASE-4 each give READY with FAULT=1, RD=0.
  - A sw to BASE+4096 leaves word 0 unchanged.
- Latency sweep for LATENCY=1, 3, 15:
  - READY rises on edge acceptance+LATENCY.
  - REQ toggled during BUSY is ignored: exactly one READY per accepted request.
- Back-to-back: REQ held high for 4 requests with LATENCY=2. Required: 4 READY pulses spaced 3 cycles apart, with data matching each request.
- Reset mid-operation: LATENCY=4 sw of 32'h12345678 to BASE+0 (prior value 32'h0), RST asserted 2 cycles after acceptance. Required: no READY, and a subsequent lw returns 32'h0.
